// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// dmem_arbiter_pkg : shared types for the data-memory arbiter   | rev 1.0
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ARB_CORE_PRI  = 2'd0,
        ARB_DMA_FORCE = 2'd1,
        ARB_DMA_LOCK  = 2'd2
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_sat_counter.sv
// ============================================================================
// arb_sat_counter : saturating event counter with limit flag     | rev 1.0
// ============================================================================
`default_nettype none

module arb_sat_counter #(
    parameter int W     = 4,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // clr together with inc restarts the count at one, so the event that
    // opens a new run is counted as part of it
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = (inc_i && (LIM != '0)) ? W'(1) : '0;
        end else if (inc_i && (cnt_q != LIM)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIM);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : core/DMA arbiter for a single-port synchronous RAM | rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int XLEN     = dmem_arbiter_pkg::XLEN,
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req_i,
    input  logic [3:0]        core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [XLEN-1:0]   core_wdata_i,
    output logic              core_stall_o,
    output logic              core_rvalid_o,
    output logic [XLEN-1:0]   core_rdata_o,
    input  logic              dma_req_i,
    input  logic              dma_lock_i,
    input  logic [3:0]        dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [XLEN-1:0]   dma_wdata_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [XLEN-1:0]   dma_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    import dmem_arbiter_pkg::*;

    localparam int WAIT_W = 8;
    localparam int LOCK_W = $clog2(LOCK_MAX) + 1;

    arb_state_e state_q, state_d;
    logic       slot_q, slot_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_owner_q, rd_owner_d;

    logic w_dma_pri;
    logic w_core_gnt;
    logic w_dma_gnt;
    logic w_wait_inc, w_wait_clr, w_wait_at_limit;
    logic w_lock_inc, w_lock_clr, w_lock_at_limit;

    arb_sat_counter #(
        .W     (WAIT_W),
        .LIMIT (MAX_WAIT - 1)
    ) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (w_wait_inc),
        .clr_i      (w_wait_clr),
        .at_limit_o (w_wait_at_limit)
    );

    arb_sat_counter #(
        .W     (LOCK_W),
        .LIMIT (LOCK_MAX - 1)
    ) u_lock_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (w_lock_inc),
        .clr_i      (w_lock_clr),
        .at_limit_o (w_lock_at_limit)
    );

    // The favoured side always wins; the other side only gets an idle slot.
    always_comb begin
        w_dma_pri = (state_q != ARB_CORE_PRI);
        if (w_dma_pri) begin
            w_dma_gnt  = dma_req_i;
            w_core_gnt = core_req_i & ~dma_req_i;
        end else begin
            w_core_gnt = core_req_i;
            w_dma_gnt  = dma_req_i & ~core_req_i;
        end
        if (!rst) begin
            w_core_gnt = 1'b0;
            w_dma_gnt  = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        slot_d     = 1'b0;
        w_wait_inc = 1'b0;
        w_wait_clr = w_dma_gnt;
        w_lock_inc = 1'b0;
        w_lock_clr = 1'b0;
        unique case (state_q)
            ARB_CORE_PRI: begin
                w_wait_inc = core_req_i & dma_req_i;
                if (w_dma_gnt && dma_lock_i) begin
                    state_d    = ARB_DMA_LOCK;
                    w_lock_clr = 1'b1;
                    w_lock_inc = 1'b1;
                end else if (slot_q && w_core_gnt && dma_req_i && dma_lock_i) begin
                    // burst resumes right after its guaranteed core slot
                    state_d    = ARB_DMA_LOCK;
                    w_lock_clr = 1'b1;
                end else if (w_wait_inc && w_wait_at_limit) begin
                    state_d = ARB_DMA_FORCE;
                end else begin
                    state_d = ARB_CORE_PRI;
                end
            end
            ARB_DMA_FORCE: begin
                w_wait_clr = 1'b1;
                if (w_dma_gnt && dma_lock_i) begin
                    state_d    = ARB_DMA_LOCK;
                    w_lock_clr = 1'b1;
                    w_lock_inc = 1'b1;
                end else begin
                    state_d = ARB_CORE_PRI;
                end
            end
            ARB_DMA_LOCK: begin
                if (dma_req_i && dma_lock_i) begin
                    if (w_lock_at_limit) begin
                        state_d = ARB_CORE_PRI;
                        slot_d  = 1'b1;
                    end else begin
                        state_d    = ARB_DMA_LOCK;
                        w_lock_inc = 1'b1;
                    end
                end else begin
                    state_d = ARB_CORE_PRI;
                end
            end
            default: state_d = ARB_CORE_PRI;
        endcase
    end

    assign rd_pend_d  = (w_core_gnt && (core_we_i == 4'd0)) ||
                        (w_dma_gnt  && (dma_we_i  == 4'd0));
    assign rd_owner_d = w_dma_gnt ? OWN_DMA : OWN_CORE;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_CORE_PRI;
            slot_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CORE;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign core_stall_o  = rst & core_req_i & ~w_core_gnt;
    assign dma_gnt_o     = w_dma_gnt;
    assign core_rvalid_o = rst & rd_pend_q & (rd_owner_q == OWN_CORE);
    assign dma_rvalid_o  = rst & rd_pend_q & (rd_owner_q == OWN_DMA);
    assign core_rdata_o  = mem_rdata_i;
    assign dma_rdata_o   = mem_rdata_i;

    assign mem_en_o    = w_core_gnt | w_dma_gnt;
    assign mem_we_o    = w_dma_gnt ? dma_we_i : (w_core_gnt ? core_we_i : 4'd0);
    assign mem_addr_o  = w_dma_gnt ? dma_addr_i  : core_addr_i;
    assign mem_wdata_o = w_dma_gnt ? dma_wdata_i : core_wdata_i;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed bench with a rule-level arbiter model | rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

    localparam int XLEN     = 32;
    localparam int ADDR_W   = 14;
    localparam int MAX_WAIT = 8;
    localparam int LOCK_MAX = 16;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              core_req;
    logic [3:0]        core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [XLEN-1:0]   core_wdata;
    logic              core_stall, core_rvalid;
    logic [XLEN-1:0]   core_rdata;
    logic              dma_req, dma_lock;
    logic [3:0]        dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [XLEN-1:0]   dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic [XLEN-1:0]   dma_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    logic [XLEN-1:0] ram    [0:DEPTH-1];
    logic [XLEN-1:0] shadow [0:DEPTH-1];

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    dmem_arbiter #(
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_stall_o (core_stall),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o (core_rdata),
        .dma_req_i    (dma_req),
        .dma_lock_i   (dma_lock),
        .dma_we_i     (dma_we),
        .dma_addr_i   (dma_addr),
        .dma_wdata_i  (dma_wdata),
        .dma_gnt_o    (dma_gnt),
        .dma_rvalid_o (dma_rvalid),
        .dma_rdata_o  (dma_rdata),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Synchronous single-port RAM, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'd0) begin
                mem_rdata <= ram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- rule-level model ----------------
    int              losses;   // consecutive contended cycles the DMA lost
    int              bcnt;     // DMA grants in the current locked burst
    bit              force_n, burst, slot;
    bit              exp_rv_c, exp_rv_d;
    logic [XLEN-1:0] exp_rd;
    bit              m_pri, m_cg, m_dg, n_force, n_burst, n_slot;
    logic [3:0]      m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [XLEN-1:0] m_wd;

    always @(negedge clk) begin
        if (running) begin
            if (!rst) begin
                chk("rst_core_stall", core_stall, 0);
                chk("rst_dma_gnt", dma_gnt, 0);
                chk("rst_core_rvalid", core_rvalid, 0);
                chk("rst_dma_rvalid", dma_rvalid, 0);
                chk("rst_mem_en", mem_en, 0);
                chk("rst_mem_we", mem_we, 0);
                losses = 0; bcnt = 0; force_n = 0; burst = 0; slot = 0;
                exp_rv_c = 0; exp_rv_d = 0;
            end else begin
                m_pri = !slot && (force_n || burst);
                if (m_pri) begin
                    m_dg = dma_req;
                    m_cg = core_req && !dma_req;
                end else begin
                    m_cg = core_req;
                    m_dg = dma_req && !core_req;
                end
                m_we   = m_dg ? dma_we : (m_cg ? core_we : 4'd0);
                m_addr = m_dg ? dma_addr : core_addr;
                m_wd   = m_dg ? dma_wdata : core_wdata;

                chk("m_core_stall", core_stall, core_req && !m_cg);
                chk("m_dma_gnt", dma_gnt, m_dg);
                chk("m_mem_en", mem_en, m_cg || m_dg);
                chk("m_mem_we", mem_we, m_we);
                if (m_cg || m_dg) begin
                    chk("m_mem_addr", mem_addr, m_addr);
                    chk("m_mem_wdata", mem_wdata, m_wd);
                end
                chk("m_core_rvalid", core_rvalid, exp_rv_c);
                chk("m_dma_rvalid", dma_rvalid, exp_rv_d);
                if (exp_rv_c) chk("m_core_rdata", core_rdata, exp_rd);
                if (exp_rv_d) chk("m_dma_rdata", dma_rdata, exp_rd);

                exp_rv_c = m_cg && (core_we == 4'd0);
                exp_rv_d = m_dg && (dma_we == 4'd0);
                if (m_cg || m_dg) begin
                    if (m_we == 4'd0) exp_rd = shadow[m_addr];
                    else for (int b = 0; b < 4; b++)
                        if (m_we[b]) shadow[m_addr][8*b +: 8] = m_wd[8*b +: 8];
                end

                n_force = 0; n_burst = 0; n_slot = 0;
                if (m_dg) losses = 0;
                else if (!m_pri && core_req && dma_req) losses++;
                if (force_n) losses = 0;
                if (m_dg && dma_lock) begin
                    if (!burst || slot) bcnt = 0;
                    bcnt++;
                    if (bcnt >= LOCK_MAX) n_slot = 1;
                    else n_burst = 1;
                end else if (slot && m_cg && dma_req && dma_lock) begin
                    n_burst = 1;
                    bcnt = 0;
                end
                if (!m_pri && core_req && dma_req && losses >= MAX_WAIT && !n_burst)
                    n_force = 1;
                force_n = n_force; burst = n_burst; slot = n_slot;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask
    task automatic adv(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int ng;
        bit exp_d;
        for (int i = 0; i < DEPTH; i++) ram[i] = {16'hC0DE, i[15:0]};
        ram[14'h004] = 32'h04040404;
        ram[14'h008] = 32'h08080808;
        ram[14'h00C] = 32'h0C0C0C0C;
        ram[14'h010] = 32'hDEADBEEF;
        ram[14'h020] = 32'hAAAABBBB;
        for (int i = 0; i < DEPTH; i++) shadow[i] = ram[i];

        idle();
        rst = 1'b0;
        running = 1'b1;
        repeat (3) adv();
        rst = 1'b1;

        // core-only read
        core_req = 1; core_addr = 14'h010;
        smp(); chk("t1_mem_en", mem_en, 1); chk("t1_stall", core_stall, 0);
        adv(); idle();
        smp(); chk("t1_rvalid", core_rvalid, 1); chk("t1_rdata", core_rdata, 32'hDEADBEEF);
        adv();

        // DMA halfword write with core idle, then read back
        dma_req = 1; dma_we = 4'b0011; dma_addr = 14'h020; dma_wdata = 32'h12345678;
        smp(); chk("t2_dma_gnt", dma_gnt, 1); chk("t2_mem_we", mem_we, 4'b0011);
        adv(); idle();
        smp(); chk("t2_no_dma_rvalid", dma_rvalid, 0); chk("t2_no_core_rvalid", core_rvalid, 0);
        core_req = 1; core_addr = 14'h020;
        adv(); idle();
        smp(); chk("t2_rb_rvalid", core_rvalid, 1); chk("t2_rb_rdata", core_rdata, 32'hAAAA5678);
        adv();

        // alternating-owner reads
        core_req = 1; core_addr = 14'h004;
        adv(); idle();
        dma_req = 1; dma_addr = 14'h008;
        smp(); chk("t3_c1_rvalid", core_rvalid, 1); chk("t3_c1_rdata", core_rdata, 32'h04040404);
        adv(); idle();
        core_req = 1; core_addr = 14'h00C;
        smp(); chk("t3_d_rvalid", dma_rvalid, 1); chk("t3_d_rdata", dma_rdata, 32'h08080808);
        adv(); idle();
        smp(); chk("t3_c2_rvalid", core_rvalid, 1); chk("t3_c2_rdata", core_rdata, 32'h0C0C0C0C);
        adv();

        // sustained contention: DMA forced through every MAX_WAIT losses
        core_req = 1; core_addr = 14'h030; dma_req = 1; dma_addr = 14'h031;
        for (int k = 0; k < 18; k++) begin
            smp();
            exp_d = (k == 8) || (k == 17);
            chk($sformatf("t4_dma_gnt_%0d", k), dma_gnt, exp_d);
            chk($sformatf("t4_stall_%0d", k), core_stall, exp_d);
            adv();
        end
        idle();
        adv();

        // locked DMA burst of 20 writes against a continuously requesting core
        ng = 0;
        for (int k = 0; k < 31; k++) begin
            core_req = 1; core_we = 0; core_addr = 14'h200;
            dma_req = (ng < 20); dma_lock = 1; dma_we = 4'hF;
            dma_addr = 14'h100 + ADDR_W'(ng); dma_wdata = 32'hB0000000 + ng;
            smp();
            exp_d = (k >= 8 && k <= 23) || (k >= 25 && k <= 28);
            chk($sformatf("t5_dma_gnt_%0d", k), dma_gnt, exp_d);
            chk($sformatf("t5_stall_%0d", k), core_stall, exp_d);
            if (dma_gnt) ng++;
            adv();
        end
        chk("t5_dma_grants", ng, 20);
        idle();
        core_req = 1; core_addr = 14'h113;
        adv(); idle();
        smp(); chk("t5_last_write", core_rdata, 32'hB0000013);
        adv();

        // reset while locked with a DMA read outstanding
        dma_req = 1; dma_lock = 1; dma_addr = 14'h008;
        smp(); chk("t6_open_gnt", dma_gnt, 1);
        adv();
        smp(); chk("t6_lock_gnt", dma_gnt, 1);
        adv();
        rst = 1'b0; core_req = 1; core_we = 4'hF; core_addr = 14'h040; core_wdata = 32'h55AA55AA;
        for (int k = 0; k < 2; k++) begin
            smp();
            chk($sformatf("t6_rst_dma_rvalid_%0d", k), dma_rvalid, 0);
            chk($sformatf("t6_rst_mem_en_%0d", k), mem_en, 0);
            chk($sformatf("t6_rst_stall_%0d", k), core_stall, 0);
            adv();
        end
        rst = 1'b1;
        smp();
        chk("t6_core_first", core_stall, 0); chk("t6_mem_en", mem_en, 1);
        chk("t6_dma_held_off", dma_gnt, 0); chk("t6_no_stale", dma_rvalid, 0);
        adv(); idle();
        smp(); chk("t6_no_stale2", dma_rvalid, 0); chk("t6_no_core_rv", core_rvalid, 0);
        adv();

        adv();
        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
